// File: rtl/cache_transfer_pipeline.sv
// Three-stage load/store mover between the dcache and the thread-banked regfile.
// Interlocks read-after-write hazards and freezes while a store waits for the write grant.
module cache_transfer_pipeline #(
    parameter int DATA_W       = 18,
    parameter int CACHE_ADDR_W = 13,
    parameter int REG_W        = 2,
    parameter int THREADS      = 2,
    parameter int TID_W        = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     instr_is_load,
    input  logic [TID_W-1:0]         instr_thread,
    input  logic [REG_W-1:0]         instr_reg,
    input  logic [CACHE_ADDR_W-1:0]  instr_cache_addr,
    output logic [TID_W+REG_W-1:0]   regfile_read_addr,
    input  logic [DATA_W-1:0]        regfile_dat_r,
    output logic [CACHE_ADDR_W-1:0]  cache_read_addr,
    input  logic [DATA_W-1:0]        cache_dat_r,
    output logic [TID_W+REG_W-1:0]   regfile_write_addr,
    output logic [DATA_W-1:0]        regfile_dat_w,
    output logic                     regfile_we,
    output logic [CACHE_ADDR_W-1:0]  cache_write_addr,
    output logic [DATA_W-1:0]        cache_dat_w,
    output logic                     cache_we,
    input  logic                     cache_wr_grant,
    output logic                     busy,
    output logic [15:0]              stat_loads,
    output logic [15:0]              stat_stores,
    output logic [15:0]              stat_stall_cycles
);

    localparam int          RA_W     = TID_W + REG_W;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef struct packed {
        logic                    valid;
        logic                    is_load;
        logic [RA_W-1:0]         rf_addr;
        logic [CACHE_ADDR_W-1:0] cache_addr;
    } stage_t;

    stage_t            s1_q;
    stage_t            s2_q;
    stage_t            s1_d;
    logic [RA_W-1:0]   instr_rf_addr;
    logic              stall;
    logic              advance;
    logic              accept;
    logic              reg_hazard;
    logic              addr_hazard;
    logic [DATA_W-1:0] s2_live_data;
    logic [DATA_W-1:0] s2_data;
    logic [DATA_W-1:0] skid_data_q;
    logic              skid_full_q;

    assign instr_rf_addr = {instr_thread, instr_reg};
    assign busy          = s1_q.valid || s2_q.valid || regfile_we || cache_we;

    // The W stage is occupied exactly when one of the write strobes is high.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        stall       = cache_we && !cache_wr_grant;
        advance     = !stall;
        reg_hazard  = 1'b0;
        addr_hazard = 1'b0;
        if (!instr_is_load) begin
            reg_hazard = (s1_q.valid && s1_q.is_load && (s1_q.rf_addr == instr_rf_addr))
                      || (s2_q.valid && s2_q.is_load && (s2_q.rf_addr == instr_rf_addr))
                      || (regfile_we && (regfile_write_addr == instr_rf_addr));
        end else begin
            addr_hazard = (s1_q.valid && !s1_q.is_load && (s1_q.cache_addr == instr_cache_addr))
                       || (s2_q.valid && !s2_q.is_load && (s2_q.cache_addr == instr_cache_addr))
                       || (cache_we && (cache_write_addr == instr_cache_addr));
        end
        instr_ready = !stall && !reg_hazard && !addr_hazard;
        accept      = instr_valid && instr_ready;

        s1_d = '0;
        if (accept) begin
            s1_d.valid      = 1'b1;
            s1_d.is_load    = instr_is_load;
            s1_d.rf_addr    = instr_rf_addr;
            s1_d.cache_addr = instr_cache_addr;
        end

        s2_live_data = s2_q.is_load ? cache_dat_r : regfile_dat_r;
        s2_data      = skid_full_q ? skid_data_q : s2_live_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (advance) begin
            s1_q <= s1_d;
            s2_q <= s1_q;
        end
    end

    // Only the port used by the accepted transfer moves; the other keeps its last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regfile_read_addr <= '0;
            cache_read_addr   <= '0;
        end else if (accept) begin
            if (instr_is_load) begin
                cache_read_addr <= instr_cache_addr;
            end else begin
                regfile_read_addr <= instr_rf_addr;
            end
        end
    end

    // Once S1 freezes its address moves on, so S2's read data must be parked on the first stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else if (advance) begin
            skid_full_q <= 1'b0;
        end else if (s2_q.valid && !skid_full_q) begin
            skid_full_q <= 1'b1;
            skid_data_q <= s2_live_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regfile_we         <= 1'b0;
            regfile_write_addr <= '0;
            regfile_dat_w      <= '0;
            cache_we           <= 1'b0;
            cache_write_addr   <= '0;
            cache_dat_w        <= '0;
        end else if (advance) begin
            regfile_we <= s2_q.valid && s2_q.is_load;
            cache_we   <= s2_q.valid && !s2_q.is_load;
            if (s2_q.valid && s2_q.is_load) begin
                regfile_write_addr <= s2_q.rf_addr;
                regfile_dat_w      <= s2_data;
            end
            if (s2_q.valid && !s2_q.is_load) begin
                cache_write_addr <= s2_q.cache_addr;
                cache_dat_w      <= s2_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads        <= '0;
            stat_stores       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (regfile_we && (stat_loads != STAT_MAX)) begin
                stat_loads <= stat_loads + 16'd1;
            end
            if (cache_we && cache_wr_grant && (stat_stores != STAT_MAX)) begin
                stat_stores <= stat_stores + 16'd1;
            end
            if (stall && (stat_stall_cycles != STAT_MAX)) begin
                stat_stall_cycles <= stat_stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_transfer_pipeline.sv
// Directed bench for cache_transfer_pipeline: streaming, grant stall with skid, hazards,
// reset during a stall and counter saturation, against bench-side regfile and dcache models.
module tb_cache_transfer_pipeline;

    localparam int DATA_W       = 18;
    localparam int CACHE_ADDR_W = 13;
    localparam int REG_W        = 2;
    localparam int THREADS      = 2;
    localparam int TID_W        = 1;
    localparam int RA_W         = TID_W + REG_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    instr_valid = 1'b0;
    logic                    instr_ready;
    logic                    instr_is_load = 1'b0;
    logic [TID_W-1:0]        instr_thread = '0;
    logic [REG_W-1:0]        instr_reg = '0;
    logic [CACHE_ADDR_W-1:0] instr_cache_addr = '0;
    logic [RA_W-1:0]         regfile_read_addr;
    logic [DATA_W-1:0]       regfile_dat_r;
    logic [CACHE_ADDR_W-1:0] cache_read_addr;
    logic [DATA_W-1:0]       cache_dat_r;
    logic [RA_W-1:0]         regfile_write_addr;
    logic [DATA_W-1:0]       regfile_dat_w;
    logic                    regfile_we;
    logic [CACHE_ADDR_W-1:0] cache_write_addr;
    logic [DATA_W-1:0]       cache_dat_w;
    logic                    cache_we;
    logic                    cache_wr_grant = 1'b1;
    logic                    busy;
    logic [15:0]             stat_loads;
    logic [15:0]             stat_stores;
    logic [15:0]             stat_stall_cycles;

    // Backdoor port into the bench memories, used only while the pipeline is idle.
    logic                    bd_rf_we = 1'b0;
    logic                    bd_cache_we = 1'b0;
    logic [CACHE_ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0]       bd_data = '0;

    logic [DATA_W-1:0] rf_mem [0:(1<<RA_W)-1];
    logic [DATA_W-1:0] cache_mem [0:(1<<CACHE_ADDR_W)-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int acc_q[$];
    int rf_cyc[$];
    int rf_a[$];
    int rf_d[$];
    int cw_cyc[$];
    int cw_a[$];
    int cw_d[$];

    cache_transfer_pipeline #(
        .DATA_W(DATA_W), .CACHE_ADDR_W(CACHE_ADDR_W), .REG_W(REG_W), .THREADS(THREADS), .TID_W(TID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_is_load(instr_is_load),
        .instr_thread(instr_thread), .instr_reg(instr_reg), .instr_cache_addr(instr_cache_addr),
        .regfile_read_addr(regfile_read_addr), .regfile_dat_r(regfile_dat_r),
        .cache_read_addr(cache_read_addr), .cache_dat_r(cache_dat_r),
        .regfile_write_addr(regfile_write_addr), .regfile_dat_w(regfile_dat_w), .regfile_we(regfile_we),
        .cache_write_addr(cache_write_addr), .cache_dat_w(cache_dat_w), .cache_we(cache_we),
        .cache_wr_grant(cache_wr_grant), .busy(busy),
        .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall_cycles(stat_stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read regfile and dcache models.
    always @(posedge clk) begin
        regfile_dat_r <= rf_mem[regfile_read_addr];
        cache_dat_r   <= cache_mem[cache_read_addr];
        if (regfile_we) rf_mem[regfile_write_addr] <= regfile_dat_w;
        if (cache_we && cache_wr_grant) cache_mem[cache_write_addr] <= cache_dat_w;
        if (bd_rf_we) rf_mem[bd_addr[RA_W-1:0]] <= bd_data;
        if (bd_cache_we) cache_mem[bd_addr] <= bd_data;
    end

    // Event log sampled just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (instr_valid && instr_ready) acc_q.push_back(cyc);
            if (regfile_we) begin
                rf_cyc.push_back(cyc); rf_a.push_back(int'(regfile_write_addr)); rf_d.push_back(int'(regfile_dat_w));
            end
            if (cache_we && cache_wr_grant) begin
                cw_cyc.push_back(cyc); cw_a.push_back(int'(cache_write_addr)); cw_d.push_back(int'(cache_dat_w));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        acc_q.delete(); rf_cyc.delete(); rf_a.delete(); rf_d.delete();
        cw_cyc.delete(); cw_a.delete(); cw_d.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        instr_valid = 1'b0; cache_wr_grant = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic bd_write(input bit to_cache, input int addr, input int data);
        @(negedge clk);
        bd_cache_we = to_cache; bd_rf_we = !to_cache;
        bd_addr = addr[CACHE_ADDR_W-1:0]; bd_data = data[DATA_W-1:0];
        @(negedge clk);
        bd_cache_we = 1'b0; bd_rf_we = 1'b0;
    endtask

    // Offers one transfer and returns once it will be taken at the next rising edge.
    task automatic issue(input bit ld, input int rf_addr, input int caddr);
        @(negedge clk);
        instr_valid = 1'b1; instr_is_load = ld;
        {instr_thread, instr_reg} = rf_addr[RA_W-1:0];
        instr_cache_addr = caddr[CACHE_ADDR_W-1:0];
        #1;
        for (int i = 0; i < 40 && !instr_ready; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_timeout ready=%b required=1", instr_ready);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", instr_ready); end
        checks++;
        if ({regfile_we, cache_we, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got=%b want=000", {regfile_we, cache_we, busy});
        end
        checks++;
        if ({regfile_read_addr, cache_read_addr, regfile_write_addr, cache_write_addr} !== '0) begin
            failures++; $display("FAIL reset_addrs got=%h want=0", {regfile_read_addr, cache_read_addr, regfile_write_addr, cache_write_addr});
        end
        checks++;
        if ({regfile_dat_w, cache_dat_w, stat_loads, stat_stores, stat_stall_cycles} !== '0) begin
            failures++; $display("FAIL reset_data_stats got=%h want=0", {regfile_dat_w, cache_dat_w, stat_loads, stat_stores, stat_stall_cycles});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_streaming_loads();
        apply_reset();
        for (int i = 0; i < 4; i++) bd_write(1'b1, 'h100 + i, 'h11 + i);
        for (int i = 0; i < 4; i++) issue(1'b1, 4 + i, 'h100 + i);
        idle(8);
        checks++;
        if (acc_q.size() != 4 || rf_cyc.size() != 4) begin
            failures++; $display("FAIL stream_counts accepts=%0d writes=%0d want=4,4", acc_q.size(), rf_cyc.size());
        end else begin
            checks++;
            if (acc_q[3] - acc_q[0] != 3) begin
                failures++; $display("FAIL stream_accept_span got=%0d want=3", acc_q[3] - acc_q[0]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rf_cyc[i] - acc_q[0] != 3 + i || rf_a[i] != 4 + i || rf_d[i] != 'h11 + i) begin
                    failures++;
                    $display("FAIL stream_write%0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             i, rf_cyc[i] - acc_q[0], rf_a[i], rf_d[i], 3 + i, 4 + i, 'h11 + i);
                end
            end
        end
        checks++;
        if (stat_loads !== 16'd4 || stat_stores !== 16'd0) begin
            failures++; $display("FAIL stream_stats loads=%0d stores=%0d want=4,0", stat_loads, stat_stores);
        end
    endtask

    task automatic test_store_grant_stall();
        int bad;
        apply_reset();
        bd_write(1'b0, 2, 'h2AAAA);
        bd_write(1'b1, 'h555, 'h15555);
        bd_write(1'b1, 'h556, 'h16666);
        cache_wr_grant = 1'b0;
        issue(1'b0, 2, 'h1FFF);
        issue(1'b1, 3, 'h555);
        issue(1'b1, 5, 'h556);
        @(negedge clk);
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && cache_we !== 1'b1; i++) @(negedge clk);
        checks++;
        if (cache_we !== 1'b1) begin failures++; $display("FAIL stall_cache_we_timeout got=%b want=1", cache_we); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (cache_we !== 1'b1 || instr_ready !== 1'b0 || regfile_we !== 1'b0 || busy !== 1'b1
                || cache_write_addr !== 13'h1FFF || cache_dat_w !== 18'h2AAAA) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d want=0", bad); end
        @(negedge clk);
        cache_wr_grant = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (stat_stall_cycles !== 16'd5 || stat_stores !== 16'd1 || stat_loads !== 16'd2) begin
            failures++;
            $display("FAIL stall_stats stall=%0d stores=%0d loads=%0d want=5,1,2", stat_stall_cycles, stat_stores, stat_loads);
        end
        checks++;
        if (cw_cyc.size() != 1 || rf_cyc.size() != 2) begin
            failures++; $display("FAIL stall_write_counts cache=%0d rf=%0d want=1,2", cw_cyc.size(), rf_cyc.size());
        end else begin
            checks++;
            if (cw_a[0] != 'h1FFF || cw_d[0] != 'h2AAAA) begin
                failures++; $display("FAIL stall_store got addr=%h data=%h want 1fff 2aaaa", cw_a[0], cw_d[0]);
            end
            checks++;
            if (rf_a[0] != 3 || rf_d[0] != 'h15555 || rf_cyc[0] - cw_cyc[0] != 1) begin
                failures++; $display("FAIL stall_skid_load got addr=%0d data=%h dt=%0d want 3 15555 1", rf_a[0], rf_d[0], rf_cyc[0] - cw_cyc[0]);
            end
            checks++;
            if (rf_a[1] != 5 || rf_d[1] != 'h16666 || rf_cyc[1] - rf_cyc[0] != 1) begin
                failures++; $display("FAIL stall_next_load got addr=%0d data=%h dt=%0d want 5 16666 1", rf_a[1], rf_d[1], rf_cyc[1] - rf_cyc[0]);
            end
        end
        checks++;
        if (busy !== 1'b0 || cache_we !== 1'b0) begin
            failures++; $display("FAIL stall_drain busy=%b cache_we=%b want 0 0", busy, cache_we);
        end
    endtask

    task automatic test_hazards();
        apply_reset();
        bd_write(1'b1, 'h200, 'h0ABCD);
        bd_write(1'b0, 1, 'h3FFFF);
        bd_write(1'b0, 2, 'h12345);
        bd_write(1'b1, 'h42, 'h00777);

        issue(1'b1, 1, 'h200);
        issue(1'b0, 1, 'h300);
        idle(10);
        checks++;
        if (acc_q.size() != 2 || cw_cyc.size() != 1) begin
            failures++; $display("FAIL reg_hazard_counts accepts=%0d stores=%0d want=2,1", acc_q.size(), cw_cyc.size());
        end else begin
            checks++;
            if (acc_q[1] - acc_q[0] != 4) begin
                failures++; $display("FAIL reg_hazard_gap got=%0d want=4", acc_q[1] - acc_q[0]);
            end
            checks++;
            if (cw_a[0] != 'h300 || cw_d[0] != 'h0ABCD) begin
                failures++; $display("FAIL reg_hazard_data got addr=%h data=%h want 300 0abcd", cw_a[0], cw_d[0]);
            end
        end
        clear_logs();

        issue(1'b0, 2, 'h40);
        issue(1'b1, 6, 'h40);
        idle(10);
        checks++;
        if (acc_q.size() != 2 || cw_cyc.size() != 1 || rf_cyc.size() != 1) begin
            failures++; $display("FAIL addr_hazard_counts accepts=%0d stores=%0d loads=%0d want=2,1,1", acc_q.size(), cw_cyc.size(), rf_cyc.size());
        end else begin
            checks++;
            if (acc_q[1] - acc_q[0] != 4 || acc_q[1] - cw_cyc[0] != 1) begin
                failures++; $display("FAIL addr_hazard_gap got=%0d after_grant=%0d want=4,1", acc_q[1] - acc_q[0], acc_q[1] - cw_cyc[0]);
            end
            checks++;
            if (rf_a[0] != 6 || rf_d[0] != 'h12345) begin
                failures++; $display("FAIL addr_hazard_data got addr=%0d data=%h want 6 12345", rf_a[0], rf_d[0]);
            end
        end
        clear_logs();

        issue(1'b0, 2, 'h41);
        issue(1'b1, 7, 'h42);
        idle(10);
        checks++;
        if (acc_q.size() != 2 || rf_cyc.size() != 1) begin
            failures++; $display("FAIL no_hazard_counts accepts=%0d loads=%0d want=2,1", acc_q.size(), rf_cyc.size());
        end else begin
            checks++;
            if (acc_q[1] - acc_q[0] != 1 || rf_a[0] != 7 || rf_d[0] != 'h777) begin
                failures++; $display("FAIL no_hazard got gap=%0d addr=%0d data=%h want 1 7 777", acc_q[1] - acc_q[0], rf_a[0], rf_d[0]);
            end
        end
        clear_logs();

        issue(1'b1, 1, 'h200);
        issue(1'b0, 5, 'h301);
        idle(10);
        checks++;
        if (acc_q.size() != 2) begin
            failures++; $display("FAIL thread_split_count accepts=%0d want=2", acc_q.size());
        end else if (acc_q[1] - acc_q[0] != 1) begin
            failures++; $display("FAIL thread_split_gap got=%0d want=1", acc_q[1] - acc_q[0]);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        cache_wr_grant = 1'b0;
        issue(1'b0, 2, 'h100);
        @(negedge clk);
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && cache_we !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (cache_we !== 1'b1 || stat_stall_cycles !== 16'd2) begin
            failures++; $display("FAIL pre_reset_stall cache_we=%b stall=%0d want 1 2", cache_we, stat_stall_cycles);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cache_we, regfile_we, busy, instr_ready} !== 4'b0001) begin
            failures++; $display("FAIL midreset_ctrl got=%b want=0001", {cache_we, regfile_we, busy, instr_ready});
        end
        checks++;
        if ({cache_write_addr, cache_dat_w, regfile_read_addr, stat_stall_cycles, stat_stores} !== '0) begin
            failures++; $display("FAIL midreset_values got=%h want=0", {cache_write_addr, cache_dat_w, regfile_read_addr, stat_stall_cycles, stat_stores});
        end
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        cache_wr_grant = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (cw_cyc.size() != 0 || rf_cyc.size() != 0 || busy !== 1'b0 || stat_stores !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_quiet cache_writes=%0d rf_writes=%0d busy=%b stores=%0d want 0 0 0 0",
                     cw_cyc.size(), rf_cyc.size(), busy, stat_stores);
        end
    endtask

    task automatic test_counter_saturation();
        apply_reset();
        for (int n = 0; n < 65534; n++) issue(1'b1, 4, 'h100);
        idle(6);
        checks++;
        if (stat_loads !== 16'hFFFE) begin failures++; $display("FAIL sat_below got=%h want=fffe", stat_loads); end
        issue(1'b1, 4, 'h100);
        idle(6);
        checks++;
        if (stat_loads !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h want=ffff", stat_loads); end
        for (int n = 0; n < 3; n++) issue(1'b1, 4, 'h100);
        idle(6);
        checks++;
        if (stat_loads !== 16'hFFFF || stat_stores !== 16'd0) begin
            failures++; $display("FAIL sat_hold loads=%h stores=%h want ffff 0", stat_loads, stat_stores);
        end
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_streaming_loads();
        test_store_grant_stall();
        test_hazards();
        test_reset_mid_stall();
        test_counter_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
